instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_pkg.sv | 58 +++++
 rtl/instr_pack.sv | 62 ++++++
 rtl/instr_encoder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder.
// Holds the mnemonic enum (codes 0-17; 18-31 are illegal), the instruction
// format enum, the opcode/funct constants and small mnemonic-class helpers
// used by the optional statistics counters (ENC_STATS_EN).
package instr_pkg;

  typedef enum logic [4:0] {
    MnAdd    = 5'd0,
    MnSub    = 5'd1,
    MnAddi   = 5'd2,
    MnAddfp  = 5'd3,
    MnMulfp  = 5'd4,
    MnVaddfp = 5'd5,
    MnVmulfp = 5'd6,
    MnVsumfp = 5'd7,
    MnSw     = 5'd8,
    MnLw     = 5'd9,
    MnSwfp   = 5'd10,
    MnLwfp   = 5'd11,
    MnVst    = 5'd12,
    MnVld    = 5'd13,
    MnBeq    = 5'd14,
    MnBlt    = 5'd15,
    MnJ      = 5'd16,
    MnVsetfp = 5'd17
  } mnem_e;

  typedef enum logic [1:0] {FmtR, FmtI, FmtJ} fmt_e;

  localparam logic [5:0] OpAlu    = 6'b000000;
  localparam logic [5:0] OpAddi   = 6'b010000;
  localparam logic [5:0] OpFp     = 6'b000100;
  localparam logic [5:0] OpVec    = 6'b001100;
  localparam logic [5:0] OpSw     = 6'b010001;
  localparam logic [5:0] OpLw     = 6'b010010;
  localparam logic [5:0] OpSwfp   = 6'b010101;
  localparam logic [5:0] OpLwfp   = 6'b010110;
  localparam logic [5:0] OpVst    = 6'b011101;
  localparam logic [5:0] OpVld    = 6'b011110;
  localparam logic [5:0] OpBeq    = 6'b100000;
  localparam logic [5:0] OpBlt    = 6'b100001;
  localparam logic [5:0] OpJ      = 6'b100010;
  localparam logic [5:0] OpVsetfp = 6'b111111;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnMul = 6'h18;
  localparam logic [5:0] FnSum = 6'h21;

  function automatic logic is_vec_op(input logic [4:0] m);
    return m inside {MnVaddfp, MnVmulfp, MnVsumfp, MnVst, MnVld, MnVsetfp};
  endfunction

  function automatic logic is_mem_op(input logic [4:0] m);
    return m inside {MnSw, MnLw, MnSwfp, MnLwfp, MnVst, MnVld};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational mnemonic-to-instruction-word encoder.
// Ports:
//   mnem   - mnemonic code (instr_pkg::mnem_e values, 18-31 illegal)
//   rs/rt/rd, imm, target - operand fields
//   word   - packed 32-bit instruction (zero when illegal)
//   legal  - mnemonic is one of the defined codes
module instr_pack import instr_pkg::*; (
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  logic [5:0] op;
  logic [5:0] funct;
  fmt_e       fmt;

  always_comb begin
    op    = '0;
    funct = '0;
    fmt   = FmtI;
    legal = 1'b1;
    unique case (mnem)
      MnAdd:    begin op = OpAlu; funct = FnAdd; fmt = FmtR; end
      MnSub:    begin op = OpAlu; funct = FnSub; fmt = FmtR; end
      MnAddi:   op = OpAddi;
      MnAddfp:  begin op = OpFp;  funct = FnAdd; fmt = FmtR; end
      MnMulfp:  begin op = OpFp;  funct = FnMul; fmt = FmtR; end
      MnVaddfp: begin op = OpVec; funct = FnAdd; fmt = FmtR; end
      MnVmulfp: begin op = OpVec; funct = FnMul; fmt = FmtR; end
      MnVsumfp: begin op = OpVec; funct = FnSum; fmt = FmtR; end
      MnSw:     op = OpSw;
      MnLw:     op = OpLw;
      MnSwfp:   op = OpSwfp;
      MnLwfp:   op = OpLwfp;
      MnVst:    op = OpVst;
      MnVld:    op = OpVld;
      MnBeq:    op = OpBeq;
      MnBlt:    op = OpBlt;
      MnJ:      begin op = OpJ; fmt = FmtJ; end
      MnVsetfp: op = OpVsetfp;
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    word = '0;
    if (legal) begin
      unique case (fmt)
        FmtR:    word = {op, rs, rt, rd, 5'b00000, funct};
        FmtI:    word = {op, rs, rt, imm};
        FmtJ:    word = {op, target};
        default: word = '0;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts encode requests, packs them into 32-bit words
// and writes them to sequential instruction-memory addresses starting at
// BASE_ADDR, one word per cycle, one cycle after acceptance.
// Optional feature macro: ENC_STATS_EN adds stat_vec/stat_mem write counters.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - request handshake (in_ready = !full && !flush)
//   mnem, rs, rt, rd, imm, target - request fields
//   flush                - synchronous restart of address, count and FULL state
//   imem_we/addr/wdata   - registered instruction-memory write port
//   full                 - top address written, no further accepts
//   err_illegal          - sticky, illegal mnemonic consumed (survives flush)
//   instr_count          - words written since reset or flush
//   stat_vec, stat_mem   - (ENC_STATS_EN only) vector / memory op write counts
module instr_encoder import instr_pkg::*; #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              flush,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              full,
  output logic              err_illegal,
  output logic [ADDR_W:0]   instr_count
`ifdef ENC_STATS_EN
  ,
  output logic [ADDR_W:0]   stat_vec,
  output logic [ADDR_W:0]   stat_mem
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StFull} state_e;

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LastAddr = '1;
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;    // next address to write
  logic [ADDR_W-1:0] addr_q, addr_d;  // address presented on imem_addr
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic [31:0] pack_word;
  logic        pack_legal;
  logic        accept;
  logic        wr;

  instr_pack u_pack (
    .mnem   (mnem),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .imm    (imm),
    .target (target),
    .word   (pack_word),
    .legal  (pack_legal)
  );

  assign full     = (state_q == StFull);
  assign in_ready = !full && !flush;
  assign accept   = in_valid && in_ready;
  assign wr       = accept && pack_legal;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (flush) begin
      // A write registered last cycle is already on the port and completes.
      state_d = StIdle;
      ptr_d   = BaseAddr;
      addr_d  = BaseAddr;
      cnt_d   = '0;
    end else if (accept) begin
      if (state_q == StIdle) state_d = StRun;
      if (pack_legal) begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = pack_word;
        cnt_d   = cnt_q + CntOne;
        // No wrap: the top address parks the pointer and stops accepts.
        if (ptr_q == LastAddr) state_d = StFull;
        else                   ptr_d   = ptr_q + AddrOne;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= BaseAddr;
      addr_q  <= BaseAddr;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign err_illegal = err_q;
  assign instr_count = cnt_q;

`ifdef ENC_STATS_EN
  logic [ADDR_W:0] stat_vec_q, stat_vec_d;
  logic [ADDR_W:0] stat_mem_q, stat_mem_d;

  always_comb begin
    stat_vec_d = stat_vec_q;
    stat_mem_d = stat_mem_q;
    if (flush) begin
      stat_vec_d = '0;
      stat_mem_d = '0;
    end else if (wr) begin
      if (is_vec_op(mnem)) stat_vec_d = stat_vec_q + CntOne;
      if (is_mem_op(mnem)) stat_mem_d = stat_mem_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_vec_q <= '0;
      stat_mem_q <= '0;
    end else begin
      stat_vec_q <= stat_vec_d;
      stat_mem_q <= stat_mem_d;
    end
  end

  assign stat_vec = stat_vec_q;
  assign stat_mem = stat_mem_q;
`endif

endmodule
